// File: rtl/bird_physics.sv
// Bird motion engine: gravity, flap impulse, terminal velocity, IDLE/FLYING/DEAD.
// Optional BIRD_CEILING_CLAMP_EN makes a top hit non-fatal (clamp and keep flying).
module bird_physics #(
    parameter int X_CENTER = 160,
    parameter int Y_CENTER = 240,
    parameter int Y_MIN = 0,
    parameter int Y_MAX = 479,
    parameter int SIZE = 4,
    parameter int GRAVITY = 1,
    parameter int FLAP_VEL = 8,
    parameter int MAX_FALL = 10,
    parameter int VEL_W = 8,
    parameter logic [7:0] FLAP_KEY = 8'h2C,
    parameter logic [7:0] START_KEY = 8'h15
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [7:0]              keycode,
    input  logic                    collide,
    output logic [9:0]              BirdX,
    output logic [9:0]              BirdY,
    output logic [9:0]              BirdS,
    output logic signed [VEL_W-1:0] bird_vel,
    output logic                    game_active,
    output logic                    game_over
);

    typedef enum logic [1:0] {IDLE, FLYING, DEAD} state_t;

    localparam logic signed [11:0] Y_BOT = 12'(Y_MAX - SIZE);
    localparam logic signed [11:0] Y_TOP = 12'(Y_MIN + SIZE);
    localparam logic [9:0] Y_BOT10 = 10'(Y_MAX - SIZE);
    localparam logic [9:0] Y_TOP10 = 10'(Y_MIN + SIZE);
    localparam logic [9:0] Y_MID = 10'(Y_CENTER);
    localparam logic signed [VEL_W-1:0] V_FLAP = VEL_W'(-FLAP_VEL);
    localparam logic signed [VEL_W-1:0] V_MAX = VEL_W'(MAX_FALL);
    localparam logic signed [VEL_W:0] V_MAX_W = (VEL_W+1)'(MAX_FALL);
    localparam logic signed [VEL_W:0] V_GRAV = (VEL_W+1)'(GRAVITY);

    state_t state, state_n;
    logic [7:0] key_prev;
    logic [9:0] y_n;
    logic signed [VEL_W-1:0] v_n;
    logic signed [VEL_W-1:0] nv;
    logic signed [VEL_W:0] vg;
    logic signed [11:0] ny;
    logic flap_evt, start_evt;

    assign BirdX = 10'(X_CENTER);
    assign BirdS = 10'(SIZE);

    assign flap_evt = (keycode == FLAP_KEY) && (key_prev != FLAP_KEY);
    assign start_evt = (keycode == START_KEY) && (key_prev != START_KEY);

    // Position and velocity sums are widened so they cannot wrap
    assign ny = $signed({2'b00, BirdY})
              + $signed({{(12-VEL_W){bird_vel[VEL_W-1]}}, bird_vel});
    assign vg = $signed({bird_vel[VEL_W-1], bird_vel}) + V_GRAV;
    assign nv = flap_evt ? V_FLAP
              : (vg > V_MAX_W) ? V_MAX : vg[VEL_W-1:0];

    always_comb begin
        state_n = state;
        y_n = BirdY;
        v_n = bird_vel;
        unique case (state)
            IDLE: begin
                y_n = Y_MID;
                v_n = '0;
                if (flap_evt) begin
                    state_n = FLYING;
                    v_n = V_FLAP;
                end
            end
            FLYING: begin
                if (collide) begin
                    state_n = DEAD;
                end else if (ny >= Y_BOT) begin
                    state_n = DEAD;
                    y_n = Y_BOT10;
                    v_n = '0;
                end else if (ny <= Y_TOP) begin
`ifdef BIRD_CEILING_CLAMP_EN
                    state_n = FLYING;
`else
                    state_n = DEAD;
`endif
                    y_n = Y_TOP10;
                    v_n = '0;
                end else begin
                    y_n = ny[9:0];
                    v_n = nv;
                end
            end
            DEAD: begin
                if (start_evt) begin
                    state_n = IDLE;
                    y_n = Y_MID;
                    v_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                y_n = Y_MID;
                v_n = '0;
            end
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state <= IDLE;
            BirdY <= Y_MID;
            bird_vel <= '0;
            key_prev <= '0;
            game_active <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state <= state_n;
            BirdY <= y_n;
            bird_vel <= v_n;
            key_prev <= keycode;
            game_active <= (state_n == FLYING);
            game_over <= (state_n == DEAD);
        end
    end

endmodule

// File: tb/tb_bird_physics.sv
// Self-checking bench for bird_physics against a frame-level game model.
// Directed scenarios plus randomized key/collide/reset traffic.
module tb_bird_physics;

    logic frame_clk = 1'b0;
    logic Reset;
    logic [7:0] keycode;
    logic collide;
    logic [9:0] BirdX, BirdY, BirdS;
    logic signed [7:0] bird_vel;
    logic game_active, game_over;

    int total = 0;
    int bad = 0;
    int my, mv, mst, mprev;

    bird_physics dut (
        .frame_clk(frame_clk),
        .Reset(Reset),
        .keycode(keycode),
        .collide(collide),
        .BirdX(BirdX),
        .BirdY(BirdY),
        .BirdS(BirdS),
        .bird_vel(bird_vel),
        .game_active(game_active),
        .game_over(game_over)
    );

    always #5 frame_clk = ~frame_clk;

    // Game model: mst 0=idle, 1=flying, 2=dead
    task automatic model(input logic [7:0] k, input logic c, input logic r);
        int ny, nv;
        bit flap, start;
        if (r) begin
            my = 240; mv = 0; mst = 0; mprev = 0;
            return;
        end
        flap = (k == 8'h2C) && (mprev != 8'h2C);
        start = (k == 8'h15) && (mprev != 8'h15);
        mprev = k;
        if (mst == 0) begin
            if (flap) begin
                mst = 1; mv = -8;
            end
        end else if (mst == 1) begin
            if (c) begin
                mst = 2;
            end else begin
                ny = my + mv;
                nv = flap ? -8 : ((mv + 1 > 10) ? 10 : mv + 1);
                if (ny + 4 >= 479) begin
                    my = 475; mv = 0; mst = 2;
                end else if (ny - 4 <= 0) begin
                    my = 4; mv = 0;
`ifndef BIRD_CEILING_CLAMP_EN
                    mst = 2;
`endif
                end else begin
                    my = ny; mv = nv;
                end
            end
        end else if (start) begin
            mst = 0; my = 240; mv = 0;
        end
    endtask

    task automatic step(input logic [7:0] k, input logic c, input logic r);
        keycode = k;
        collide = c;
        Reset = r;
        @(posedge frame_clk);
        #1;
        model(k, c, r);
    endtask

    task automatic test_reset();
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        total++;
        if (BirdY !== 10'd240 || bird_vel !== 8'sd0 ||
            game_active !== 1'b0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL reset: got y=%0d v=%0d a=%b o=%b want y=240 v=0 a=0 o=0",
                     BirdY, bird_vel, game_active, game_over);
        end
        total++;
        if (BirdX !== 10'd160 || BirdS !== 10'd4) begin
            bad++;
            $display("FAIL consts: got x=%0d s=%0d want x=160 s=4", BirdX, BirdS);
        end
    endtask

    task automatic test_flap();
        logic [7:0] ks[3] = '{8'h2C, 8'h00, 8'h00};
        int ey[3] = '{240, 232, 225};
        int ev[3] = '{-8, -7, -6};
        for (int i = 0; i < 3; i++) begin
            step(ks[i], 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(ey[i]) || $signed(bird_vel) !== ev[i] ||
                game_active !== 1'b1 || game_over !== 1'b0) begin
                bad++;
                $display("FAIL flap[%0d]: got y=%0d v=%0d a=%b o=%b want y=%0d v=%0d a=1 o=0",
                         i, BirdY, bird_vel, game_active, game_over, ey[i], ev[i]);
            end
        end
    endtask

    task automatic test_held_flap();
        for (int i = 0; i < 20; i++) begin
            step(8'h2C, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(my) || $signed(bird_vel) !== mv ||
                game_active !== (mst == 1) || $signed(bird_vel) > 10) begin
                bad++;
                $display("FAIL held[%0d]: got y=%0d v=%0d a=%b want y=%0d v=%0d st=%0d",
                         i, BirdY, bird_vel, game_active, my, mv, mst);
            end
        end
    endtask

    task automatic test_bottom();
        bit hit = 0;
        bit saw_max = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step(8'h00, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(my) || $signed(bird_vel) !== mv ||
                game_over !== (mst == 2) || $signed(bird_vel) > 10) begin
                bad++;
                $display("FAIL fall[%0d]: got y=%0d v=%0d o=%b want y=%0d v=%0d st=%0d",
                         i, BirdY, bird_vel, game_over, my, mv, mst);
            end
            if (mv == 10) saw_max = 1;
            hit = (mst == 2);
        end
        total++;
        if (!hit || !saw_max) begin
            bad++;
            $display("FAIL fall_bound: got hit=%b max_seen=%b want 1 1", hit, saw_max);
        end
        total++;
        if (BirdY !== 10'd475 || bird_vel !== 8'sd0 ||
            game_over !== 1'b1 || game_active !== 1'b0) begin
            bad++;
            $display("FAIL bottom: got y=%0d v=%0d a=%b o=%b want y=475 v=0 a=0 o=1",
                     BirdY, bird_vel, game_active, game_over);
        end
        for (int i = 0; i < 4; i++) begin
            step((i % 2 == 0) ? 8'h2C : 8'h00, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'd475 || game_over !== 1'b1) begin
                bad++;
                $display("FAIL dead_hold[%0d]: got y=%0d o=%b want y=475 o=1",
                         i, BirdY, game_over);
            end
        end
    endtask

    task automatic test_restart();
        step(8'h15, 1'b0, 1'b0);
        total++;
        if (BirdY !== 10'd240 || bird_vel !== 8'sd0 ||
            game_active !== 1'b0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL restart: got y=%0d v=%0d a=%b o=%b want y=240 v=0 a=0 o=0",
                     BirdY, bird_vel, game_active, game_over);
        end
        step(8'h15, 1'b1, 1'b0);
        total++;
        if (BirdY !== 10'd240 || game_active !== 1'b0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got y=%0d a=%b o=%b want y=240 a=0 o=0",
                     BirdY, game_active, game_over);
        end
    endtask

    task automatic test_collide();
        int py, pv;
        step(8'h2C, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(8'h00, 1'b0, 1'b0);
        py = my;
        pv = mv;
        step(8'h00, 1'b1, 1'b0);
        total++;
        if (BirdY !== 10'(py) || $signed(bird_vel) !== pv ||
            game_over !== 1'b1 || game_active !== 1'b0) begin
            bad++;
            $display("FAIL collide: got y=%0d v=%0d a=%b o=%b want y=%0d v=%0d a=0 o=1",
                     BirdY, bird_vel, game_active, game_over, py, pv);
        end
        for (int i = 0; i < 3; i++) begin
            step((i % 2 == 0) ? 8'h2C : 8'h00, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(py) || $signed(bird_vel) !== pv || game_over !== 1'b1) begin
                bad++;
                $display("FAIL dead_flap[%0d]: got y=%0d v=%0d o=%b want y=%0d v=%0d o=1",
                         i, BirdY, bird_vel, game_over, py, pv);
            end
        end
        step(8'h15, 1'b0, 1'b0);
    endtask

    task automatic test_ceiling();
        bit top = 0;
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 200 && !top; i++) begin
            step((i % 2 == 0) ? 8'h2C : 8'h00, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(my) || $signed(bird_vel) !== mv ||
                game_active !== (mst == 1) || game_over !== (mst == 2)) begin
                bad++;
                $display("FAIL climb[%0d]: got y=%0d v=%0d a=%b o=%b want y=%0d v=%0d st=%0d",
                         i, BirdY, bird_vel, game_active, game_over, my, mv, mst);
            end
            top = (my == 4);
        end
        total++;
`ifdef BIRD_CEILING_CLAMP_EN
        if (!top || BirdY !== 10'd4 || bird_vel !== 8'sd0 ||
            game_active !== 1'b1 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL ceiling: got top=%b y=%0d v=%0d a=%b o=%b want y=4 v=0 a=1 o=0",
                     top, BirdY, bird_vel, game_active, game_over);
        end
`else
        if (!top || BirdY !== 10'd4 || bird_vel !== 8'sd0 ||
            game_active !== 1'b0 || game_over !== 1'b1) begin
            bad++;
            $display("FAIL ceiling: got top=%b y=%0d v=%0d a=%b o=%b want y=4 v=0 a=0 o=1",
                     top, BirdY, bird_vel, game_active, game_over);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            step(8'h00, 1'b0, 1'b0);
            total++;
            if (BirdY !== 10'(my) || game_active !== (mst == 1)) begin
                bad++;
                $display("FAIL top_hold[%0d]: got y=%0d a=%b want y=%0d st=%0d",
                         i, BirdY, game_active, my, mst);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] k;
        logic c, r;
        int sel;
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 800; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) k = 8'h00;
            else if (sel < 7) k = 8'h2C;
            else if (sel < 9) k = 8'h15;
            else k = 8'($urandom);
            c = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 99) < 2);
            step(k, c, r);
            total++;
            if (BirdY !== 10'(my) || $signed(bird_vel) !== mv ||
                game_active !== (mst == 1) || game_over !== (mst == 2)) begin
                bad++;
                $display("FAIL rand[%0d] k=%h c=%b r=%b: got y=%0d v=%0d a=%b o=%b want y=%0d v=%0d st=%0d",
                         i, k, c, r, BirdY, bird_vel, game_active, game_over, my, mv, mst);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 8'h00;
        collide = 1'b0;
        test_reset();
        test_flap();
        test_held_flap();
        test_bottom();
        test_restart();
        test_collide();
        test_ceiling();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
